// File: rtl/soc_code_ram_arb_if.sv
// One requester's view of the shared code RAM: request, grant and read return.
// The requester drives the master side; the arbiter takes the slave side.
interface soc_code_ram_arb_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 12
);
    logic                 Req;
    logic                 Write;
    logic [ADDRWIDTH-1:0] Addr;
    logic [DATAWIDTH-1:0] WData;
    logic                 Gnt;
    logic                 RValid;
    logic [DATAWIDTH-1:0] RData;

    modport master (output Req, Write, Addr, WData, input Gnt, RValid, RData);
    modport slave  (input Req, Write, Addr, WData, output Gnt, RValid, RData);
endinterface

// File: rtl/soc_code_ram_arb.sv
// Round-robin arbiter with a bounded burst hold that shares one single-port code RAM
// between CPU fetch (R0) and loader/debug (R1), and steers read data back to the reader.
module soc_code_ram_arb #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 12,
    parameter int MAXBURST  = 4
) (
    input  logic                 PortAClk,
    input  logic                 PortAResetn,
    soc_code_ram_arb_if.slave    R0,
    soc_code_ram_arb_if.slave    R1,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut
);
    localparam int CNTW = $clog2(MAXBURST + 1);
    localparam logic [CNTW-1:0] MAXCNT = CNTW'(MAXBURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state, nextState;
    logic [CNTW-1:0] cnt, nextCnt;
    logic            gnt0, gnt1;
    logic            rv0, rv1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PortAClk or negedge PortAResetn) begin
        if (!PortAResetn) begin
            state <= IDLE;
            cnt   <= '0;
            rv0   <= 1'b0;
            rv1   <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            rv0   <= gnt0 && !R0.Write;
            rv1   <= gnt1 && !R1.Write;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        nextState = IDLE;
        nextCnt   = '0;

        if (R0.Req && R1.Req) begin
            // The current owner keeps the RAM until it has used up its burst allowance.
            unique case (state)
                OWN0:    begin gnt0 = (cnt < MAXCNT);  gnt1 = (cnt == MAXCNT); end
                OWN1:    begin gnt1 = (cnt < MAXCNT);  gnt0 = (cnt == MAXCNT); end
                default: gnt0 = 1'b1;
            endcase
        end else begin
            gnt0 = R0.Req;
            gnt1 = R1.Req;
        end

        if (gnt0) begin
            nextState = OWN0;
            nextCnt   = (state != OWN0) ? CNTW'(1) : (cnt == MAXCNT) ? MAXCNT : cnt + 1'b1;
        end else if (gnt1) begin
            nextState = OWN1;
            nextCnt   = (state != OWN1) ? CNTW'(1) : (cnt == MAXCNT) ? MAXCNT : cnt + 1'b1;
        end
    end

    always_comb begin
        R0.Gnt         = gnt0;
        R1.Gnt         = gnt1;
        R0.RValid      = rv0;
        R1.RValid      = rv1;
        R0.RData       = RamDataOut;
        R1.RData       = RamDataOut;
        RamWriteEnable = 1'b0;
        RamAddr        = '0;
        RamDataIn      = '0;

        if (gnt0) begin
            RamWriteEnable = R0.Write;
            RamAddr        = R0.Addr;
            RamDataIn      = R0.WData;
        end else if (gnt1) begin
            RamWriteEnable = R1.Write;
            RamAddr        = R1.Addr;
            RamDataIn      = R1.WData;
        end
    end
endmodule
